pipe_adder: RTL
===============

# pipe_adder

Parametrised, pipelined carry-lookahead adder/subtractor with valid/ready handshake on both sides. The operand is split into `Stages` equal slices. Each pipeline stage resolves one slice and passes its carry to the next, so clock frequency scales with slice width, not full width. It sits between operand-producing logic and any consumer that can apply backpressure, and sustains one operation per cycle.

## Interface
- `Width`, 16, operand/result width in bits; must satisfy `Width % Stages == 0`.
- `Stages`, 4, pipeline depth and number of slices; 1 ≤ `Stages` ≤ `Width`. Slice width is `Width/Stages`.

- `clk_i` in 1: single clock; all logic on rising edge.
- `rst_i` in 1: reset, synchronous, active-high.
- `valid_i` in 1: input operation valid.
- `ready_o` out 1: block can accept an input this cycle.
- `a_i` in `Width`: operand A.
- `b_i` in `Width`: operand B.
- `sub_i` in 1: 0 = add, 1 = subtract.
- `carry_i` in 1: carry-in when adding; borrow-in when subtracting.
- `valid_o` out 1: result valid.
- `ready_i` in 1: consumer accepts result this cycle.
- `result_o` out `Width`: sum/difference.
- `carry_o` out 1: carry out of MSB. When subtracting, 1 = no borrow.
- `overflow_o` out 1: two's-complement signed overflow.

## Operation
- Input transfer occurs when `valid_i & ready_o`. Output transfer occurs when `valid_o & ready_i`.
- Effective operands at capture:
  - `b_eff = sub_i ? ~b_i : b_i`
  - `cin = carry_i ^ sub_i`
  - Add computes a+b+carry_i. Subtract computes a−b−carry_i.
- Stage k (0-based) computes slice k (`Width/Stages` bits) from the delayed operand slices and the registered carry from stage k−1. Stage 0 uses `cin`.
- Stage registers hold per stage:
  - valid bit
  - carry out of the slice
  - completed result slices 0..k
  - pending operand slices k+1..Stages−1
- The last stage additionally registers the carry into the MSB.
- `overflow_o = carry_into_msb ^ carry_o`, registered alongside the result.
- Global stall: `advance = ~valid_o | ready_i`, and `ready_o = advance`.
  - When `advance` is 0, every stage register holds.
  - Mid-pipe bubbles are not compressed.
  - `ready_o` depends combinationally on `ready_i`. This is intended; there is no combinational path from `valid_i` to any output.
- Results leave in acceptance order. None are dropped or duplicated.

## Timing
- Reset, while `rst_i` is high and on the first cycle after:
  - all stage valid bits are 0
  - `valid_o = 0`
  - `result_o = 0`, `carry_o = 0`, `overflow_o = 0`
  - `ready_o = 1`, because the pipe is empty
- Latency: an input accepted at edge N with no stall appears with `valid_o = 1` after edge N+`Stages−1`, i.e. `Stages` cycles. With `Stages = 1`, the result is visible the cycle after acceptance.
- Throughput: one op per cycle while `ready_i = 1`.
- Stall: while `valid_o & ~ready_i`, `result_o`, `carry_o` and `overflow_o` must stay stable, and no input is accepted.
- Simultaneous output transfer and input transfer in the same cycle is legal and required for full throughput.
- Reset mid-operation: all in-flight operations are discarded. No stale result may appear after `rst_i` deasserts.
- Slice carry wrap: a carry generated in slice 0 must propagate through all later slices across cycles, e.g. 0xFFFF+1.

## Structure
- Shared package `adder_pkg`:
  - localparams `ModeAdd = 1'b0`, `ModeSub = 1'b1`
  - function `slice_w(width, stages)` returning the slice width
- Sub-module `cla_slice`:
  - combinational, parameter `SliceWidth`
  - inputs: a, b, cin
  - outputs: sum, cout, carry-into-MSB
  - computes generate/propagate and lookahead carry internally
- `pipe_adder` instantiates one `cla_slice` per stage via a generate loop.
- `pipe_adder` owns all registers and the handshake.

## Test plan
All scenarios use `Width = 16`, `Stages = 4` unless noted.
- Add: 0x1234 + 0x0FFF, `carry_i = 0` -> `result_o = 0x2233`, `carry_o = 0`, `overflow_o = 0`; `valid_o` rises exactly 4 cycles after acceptance.
- Full-width ripple: 0xFFFF + 0x0000, `carry_i = 1` -> 0x0000, `carry_o = 1`, `overflow_o = 0`. Signed overflow: 0x7FFF + 0x0001 -> 0x8000, `carry_o = 0`, `overflow_o = 1`.
- Subtract: 0x0005 − 0x0007 -> 0xFFFE, `carry_o = 0`, `overflow_o = 0`. 0x8000 − 0x0001 -> 0x7FFF, `carry_o = 1`, `overflow_o = 1`. 0x0005 − 0x0002 with `carry_i = 1` (borrow) -> 0x0002.
- Backpressure: 200 back-to-back random ops with random `valid_i` and `ready_i` -> outputs match the reference model in order, count in equals count out, and outputs are stable during every stall cycle.
- Reset mid-stream: 3 ops in flight, `rst_i` high for 1 cycle -> `valid_o = 0`, all outputs 0, `ready_o = 1`, and no in-flight result ever emerges.
- Corner configs: `Width = 8`, `Stages = 1` and `Width = 8`, `Stages = 8`, random ops -> correct results with latency 1 and 8 respectively.

Source files
------------

// File: rtl/adder_pkg.sv
// Shared definitions for the pipelined adder/subtractor.
package adder_pkg;

    localparam logic ModeAdd = 1'b0;
    localparam logic ModeSub = 1'b1;

    function automatic int unsigned slice_w(input int unsigned width, input int unsigned stages);
        return width / stages;
    endfunction

endpackage

// File: rtl/cla_slice.sv
// Combinational carry-lookahead adder slice; also exposes the carry into its MSB.
module cla_slice #(
    parameter int unsigned SliceWidth = 4
) (
    input  logic [SliceWidth-1:0] a,
    input  logic [SliceWidth-1:0] b,
    input  logic                  cin,
    output logic [SliceWidth-1:0] sum,
    output logic                  cout,
    output logic                  cmsb
);

    logic [SliceWidth-1:0] gen;
    logic [SliceWidth-1:0] prop;
    logic [SliceWidth:0]   carry;
    logic                  acc;
    logic                  pacc;

    assign gen  = a & b;
    assign prop = a ^ b;

    // Each carry is a flat sum of generate terms gated by the propagate chain above them.
    always_comb begin
        carry    = '0;
        acc      = 1'b0;
        pacc     = 1'b1;
        carry[0] = cin;
        for (int unsigned i = 0; i < SliceWidth; i++) begin
            acc  = 1'b0;
            pacc = 1'b1;
            for (int j = int'(i); j >= 0; j--) begin
                acc  = acc | (pacc & gen[j]);
                pacc = pacc & prop[j];
            end
            carry[i+1] = acc | (pacc & cin);
        end
    end

    assign sum  = prop ^ carry[SliceWidth-1:0];
    assign cout = carry[SliceWidth];
    assign cmsb = carry[SliceWidth-1];

endmodule

// File: rtl/pipe_adder.sv
// Pipelined adder/subtractor: one operand slice resolved per stage, global-stall handshake.
module pipe_adder
    import adder_pkg::*;
#(
    parameter int unsigned Width  = 16,
    parameter int unsigned Stages = 4
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             valid_i,
    output logic             ready_o,
    input  logic [Width-1:0] a_i,
    input  logic [Width-1:0] b_i,
    input  logic             sub_i,
    input  logic             carry_i,
    output logic             valid_o,
    input  logic             ready_i,
    output logic [Width-1:0] result_o,
    output logic             carry_o,
    output logic             overflow_o
);

    localparam int unsigned SliceW = slice_w(Width, Stages);

    logic             advance;

    logic             valid_q [Stages];
    logic             carry_q [Stages];
    logic [Width-1:0] res_q   [Stages];
    logic [Width-1:0] a_q     [Stages];
    logic [Width-1:0] b_q     [Stages];
    logic             cmsb_q;

    logic             valid_in [Stages];
    logic             cin_in   [Stages];
    logic [Width-1:0] a_in     [Stages];
    logic [Width-1:0] b_in     [Stages];
    logic [Width-1:0] res_in   [Stages];

    logic [SliceW-1:0] sum  [Stages];
    logic              cout [Stages];
    logic              cmsb [Stages];

    for (genvar k = 0; k < Stages; k++) begin : g_stage
        if (k == 0) begin : g_first
            assign valid_in[k] = valid_i;
            assign a_in[k]     = a_i;
            assign b_in[k]     = (sub_i == ModeSub) ? ~b_i : b_i;
            assign cin_in[k]   = carry_i ^ sub_i;
            assign res_in[k]   = '0;
        end else begin : g_rest
            assign valid_in[k] = valid_q[k-1];
            assign a_in[k]     = a_q[k-1];
            assign b_in[k]     = b_q[k-1];
            assign cin_in[k]   = carry_q[k-1];
            assign res_in[k]   = res_q[k-1];
        end

        cla_slice #(
            .SliceWidth(SliceW)
        ) u_slice (
            .a   (a_in[k][k*SliceW +: SliceW]),
            .b   (b_in[k][k*SliceW +: SliceW]),
            .cin (cin_in[k]),
            .sum (sum[k]),
            .cout(cout[k]),
            .cmsb(cmsb[k])
        );
    end

    // The whole pipe holds together; bubbles are carried along rather than squeezed out.
    assign advance = ~valid_o | ready_i;
    assign ready_o = advance;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            for (int unsigned k = 0; k < Stages; k++) begin
                valid_q[k] <= 1'b0;
                carry_q[k] <= 1'b0;
                res_q[k]   <= '0;
                a_q[k]     <= '0;
                b_q[k]     <= '0;
            end
            cmsb_q <= 1'b0;
        end else if (advance) begin
            for (int unsigned k = 0; k < Stages; k++) begin
                valid_q[k]                   <= valid_in[k];
                carry_q[k]                   <= cout[k];
                a_q[k]                       <= a_in[k];
                b_q[k]                       <= b_in[k];
                res_q[k]                     <= res_in[k];
                res_q[k][k*SliceW +: SliceW] <= sum[k];
            end
            cmsb_q <= cmsb[Stages-1];
        end
    end

    assign valid_o    = valid_q[Stages-1];
    assign result_o   = res_q[Stages-1];
    assign carry_o    = carry_q[Stages-1];
    assign overflow_o = cmsb_q ^ carry_q[Stages-1];

endmodule
